// File: rtl/clarvi_soc_led_ctrl.sv
// clarvi_soc_led_ctrl: Avalon-MM LED/GPIO output register block
// with per-channel blink driven by one shared prescaled phase.
module clarvi_soc_led_ctrl #(
   parameter int WIDTH      = 10,
   parameter int PRESCALE_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_SET    = 3'd1;
   localparam logic [2:0] A_CLEAR  = 3'd2;
   localparam logic [2:0] A_TOGGLE = 3'd3;
   localparam logic [2:0] A_BLINK  = 3'd4;
   localparam logic [2:0] A_PERIOD = 3'd5;
   localparam logic [2:0] A_STATUS = 3'd6;

   logic [WIDTH-1:0]      data_out;
   logic [WIDTH-1:0]      blink_en;
   logic [PRESCALE_W-1:0] period;
   logic [PRESCALE_W-1:0] counter;
   logic                  phase;
   logic                  wr;
   logic                  blinking;
   logic                  period_wr;
   logic [WIDTH-1:0]      wd_w;
   logic [PRESCALE_W-1:0] wd_p;
   logic                  unused_wd;

   assign wr        = chipselect & ~write_n;
   assign period_wr = wr && (address == A_PERIOD);
   assign wd_w      = writedata[WIDTH-1:0];
   assign wd_p      = writedata[PRESCALE_W-1:0];
   assign blinking  = |blink_en;
   assign unused_wd = ^writedata;

   // Register file updates from bus writes
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out <= '0;
         blink_en <= '0;
         period   <= '0;
      end else if (wr) begin
         case (address)
            A_DATA:   data_out <= wd_w;
            A_SET:    data_out <= data_out | wd_w;
            A_CLEAR:  data_out <= data_out & ~wd_w;
            A_TOGGLE: data_out <= data_out ^ wd_w;
            A_BLINK:  blink_en <= wd_w;
            A_PERIOD: period   <= wd_p;
            default:  ;
         endcase
      end
   end

   // Blink prescaler; a PERIOD write restarts it, an empty mask parks it
   always_ff @(posedge clk) begin
      if (reset) begin
         counter <= '0;
         phase   <= 1'b0;
      end else if (period_wr || !blinking) begin
         counter <= '0;
         phase   <= 1'b0;
      end else if (counter == period) begin
         counter <= '0;
         phase   <= ~phase;
      end else begin
         counter <= counter + PRESCALE_W'(1);
      end
   end

   // Address-decoded read mux, zero-extended
   always_comb begin
      readdata = '0;
      case (address)
         A_DATA:   readdata[WIDTH-1:0]      = data_out;
         A_BLINK:  readdata[WIDTH-1:0]      = blink_en;
         A_PERIOD: readdata[PRESCALE_W-1:0] = period;
         A_STATUS: readdata[1:0]            = {blinking, phase};
         default:  ;
      endcase
   end

   assign out_port = data_out ^ (blink_en & {WIDTH{phase}});

endmodule

// File: tb/tb_clarvi_soc_led_ctrl.sv
// tb_clarvi_soc_led_ctrl: scoreboard bench for the LED controller,
// register map, blink timing, wrap priority and reset override.
module tb_clarvi_soc_led_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [9:0]  out_port;

   int n_vec  = 0;
   int n_miss = 0;
   logic [31:0] exp_q[$];

   typedef struct packed {
      logic        w;
      logic [2:0]  wa;
      logic [31:0] wd;
      logic [2:0]  ra;
      logic [31:0] erd;
      logic [31:0] eout;
   } step_t;

   clarvi_soc_led_ctrl #(.WIDTH(10), .PRESCALE_W(24)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] e, g;
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = 3'd0;
      writedata  = 32'h3FF;
      do_reset();
      chipselect = 1'b0;
      write_n    = 1'b1;
      for (int a = 0; a < 9; a++) begin
         exp_q.push_back(32'h0);
         if (a < 8) begin
            address = 3'(a);
            #1;
            g = readdata;
         end else begin
            g = 32'(out_port);
         end
         e = exp_q.pop_front();
         n_vec++;
         if (g !== e) begin
            n_miss++;
            $display("FAIL reset[%0d]: got %h want %h", a, g, e);
         end
      end
   endtask

   task automatic test_data();
      logic [31:0] e;
      step_t t[2];
      t = '{'{1'b1, 3'd0, 32'h3FF,      3'd0, 32'h3FF, 32'h3FF},
            '{1'b1, 3'd0, 32'hFFFF_FFFF, 3'd0, 32'h3FF, 32'h3FF}};
      foreach (t[i]) begin
         exp_q.push_back(t[i].erd);
         exp_q.push_back(t[i].eout);
         if (t[i].w) wr(t[i].wa, t[i].wd);
         address = t[i].ra;
         #1;
         e = exp_q.pop_front();
         n_vec++;
         if (readdata !== e) begin
            n_miss++;
            $display("FAIL data[%0d] rd: got %h want %h", i, readdata, e);
         end
         e = exp_q.pop_front();
         n_vec++;
         if (32'(out_port) !== e) begin
            n_miss++;
            $display("FAIL data[%0d] out: got %h want %h", i, out_port, e);
         end
      end
   endtask

   task automatic test_set_clear_toggle();
      logic [31:0] e;
      step_t t[7];
      t = '{'{1'b1, 3'd0, 32'h0F0, 3'd0, 32'h0F0, 32'h0F0},
            '{1'b1, 3'd1, 32'h003, 3'd0, 32'h0F3, 32'h0F3},
            '{1'b1, 3'd2, 32'h030, 3'd0, 32'h0C3, 32'h0C3},
            '{1'b1, 3'd3, 32'h101, 3'd0, 32'h1C2, 32'h1C2},
            '{1'b0, 3'd0, 32'h0,   3'd1, 32'h0,   32'h1C2},
            '{1'b0, 3'd0, 32'h0,   3'd2, 32'h0,   32'h1C2},
            '{1'b0, 3'd0, 32'h0,   3'd3, 32'h0,   32'h1C2}};
      foreach (t[i]) begin
         exp_q.push_back(t[i].erd);
         exp_q.push_back(t[i].eout);
         if (t[i].w) wr(t[i].wa, t[i].wd);
         address = t[i].ra;
         #1;
         e = exp_q.pop_front();
         n_vec++;
         if (readdata !== e) begin
            n_miss++;
            $display("FAIL sct[%0d] rd: got %h want %h", i, readdata, e);
         end
         e = exp_q.pop_front();
         n_vec++;
         if (32'(out_port) !== e) begin
            n_miss++;
            $display("FAIL sct[%0d] out: got %h want %h", i, out_port, e);
         end
      end
   endtask

   task automatic test_ignored();
      logic [31:0] e;
      step_t t[6];
      t = '{'{1'b1, 3'd6, 32'hFFFF_FFFF, 3'd0, 32'h1C2,       32'h1C2},
            '{1'b1, 3'd7, 32'hFFFF_FFFF, 3'd7, 32'h0,         32'h1C2},
            '{1'b1, 3'd7, 32'h0,         3'd0, 32'h1C2,       32'h1C2},
            '{1'b1, 3'd5, 32'hFFFF_FFFF, 3'd5, 32'h00FF_FFFF, 32'h1C2},
            '{1'b1, 3'd4, 32'hFFFF_FC00, 3'd4, 32'h0,         32'h1C2},
            '{1'b0, 3'd0, 32'h0,         3'd6, 32'h0,         32'h1C2}};
      foreach (t[i]) begin
         exp_q.push_back(t[i].erd);
         exp_q.push_back(t[i].eout);
         if (t[i].w) wr(t[i].wa, t[i].wd);
         address = t[i].ra;
         #1;
         e = exp_q.pop_front();
         n_vec++;
         if (readdata !== e) begin
            n_miss++;
            $display("FAIL ign[%0d] rd: got %h want %h", i, readdata, e);
         end
         e = exp_q.pop_front();
         n_vec++;
         if (32'(out_port) !== e) begin
            n_miss++;
            $display("FAIL ign[%0d] out: got %h want %h", i, out_port, e);
         end
      end
      exp_q.push_back(32'h1C2);
      address    = 3'd0;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = 32'h0;
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (readdata !== e) begin
         n_miss++;
         $display("FAIL rd_during_wr: got %h want %h", readdata, e);
      end
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic test_blink_slow();
      logic [31:0] e;
      logic ph;
      do_reset();
      wr(3'd5, 32'd3);
      wr(3'd0, 32'h0);
      wr(3'd4, 32'h001);
      address = 3'd6;
      for (int k = 0; k < 16; k++) begin
         ph = ((k / 4) % 2) != 0;
         exp_q.push_back({31'b0, ph});
         exp_q.push_back({30'b0, 1'b1, ph});
         address = 3'd6;
         #1;
         e = exp_q.pop_front();
         n_vec++;
         if (32'(out_port) !== e) begin
            n_miss++;
            $display("FAIL blink_slow[%0d] out: got %h want %h", k, out_port, e);
         end
         e = exp_q.pop_front();
         n_vec++;
         if (readdata !== e) begin
            n_miss++;
            $display("FAIL blink_slow[%0d] status: got %h want %h", k, readdata, e);
         end
         if (k == 5) wr(3'd1, 32'h0);
         else tick();
      end
   endtask

   task automatic test_blink_fast();
      logic [31:0] e;
      do_reset();
      wr(3'd5, 32'd0);
      wr(3'd0, 32'h0AA);
      wr(3'd4, 32'h3FF);
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back((k % 2) != 0 ? 32'h355 : 32'h0AA);
         e = exp_q.pop_front();
         n_vec++;
         if (32'(out_port) !== e) begin
            n_miss++;
            $display("FAIL blink_fast[%0d]: got %h want %h", k, out_port, e);
         end
         tick();
      end
      wr(3'd4, 32'h0);
      tick();
      address = 3'd6;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(32'h0AA);
         exp_q.push_back(32'h0);
         #1;
         e = exp_q.pop_front();
         n_vec++;
         if (32'(out_port) !== e) begin
            n_miss++;
            $display("FAIL blink_off[%0d] out: got %h want %h", k, out_port, e);
         end
         e = exp_q.pop_front();
         n_vec++;
         if (readdata !== e) begin
            n_miss++;
            $display("FAIL blink_off[%0d] status: got %h want %h", k, readdata, e);
         end
         tick();
      end
   endtask

   task automatic test_wrap_priority();
      logic [31:0] e;
      do_reset();
      wr(3'd5, 32'd3);
      wr(3'd0, 32'h0);
      wr(3'd4, 32'h001);
      repeat (3) tick();
      wr(3'd5, 32'd3);
      address = 3'd6;
      for (int k = 0; k < 6; k++) begin
         exp_q.push_back((k < 4) ? 32'h2 : 32'h3);
         #1;
         e = exp_q.pop_front();
         n_vec++;
         if (readdata !== e) begin
            n_miss++;
            $display("FAIL wrap_prio[%0d]: got %h want %h", k, readdata, e);
         end
         tick();
      end
   endtask

   task automatic test_reset_override();
      logic [31:0] e;
      do_reset();
      wr(3'd5, 32'd0);
      wr(3'd0, 32'h0AA);
      wr(3'd4, 32'h3FF);
      repeat (3) tick();
      reset      = 1'b1;
      address    = 3'd0;
      writedata  = 32'h155;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      reset      = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      exp_q.push_back(32'h0);
      e = exp_q.pop_front();
      n_vec++;
      if (32'(out_port) !== e) begin
         n_miss++;
         $display("FAIL rst_ovr out: got %h want %h", out_port, e);
      end
      for (int a = 0; a < 8; a++) begin
         exp_q.push_back(32'h0);
         address = 3'(a);
         #1;
         e = exp_q.pop_front();
         n_vec++;
         if (readdata !== e) begin
            n_miss++;
            $display("FAIL rst_ovr rd[%0d]: got %h want %h", a, readdata, e);
         end
      end
      tick();
      exp_q.push_back(32'h0);
      e = exp_q.pop_front();
      n_vec++;
      if (32'(out_port) !== e) begin
         n_miss++;
         $display("FAIL rst_ovr resume: got %h want %h", out_port, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      repeat (2) tick();
      test_reset();
      test_data();
      test_set_clear_toggle();
      test_ignored();
      test_blink_slow();
      test_blink_fast();
      test_wrap_priority();
      test_reset_override();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/clarvi_soc_led_ctrl.md
CLARVI_SOC_LED_CTRL -- requirements
Module: clarvi_soc_led_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 10, number of output channels (1..32).
REQ-002 SHALL have parameter PRESCALE_W, default 24, width of blink period register/counter (1..32).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port address  input  3  Avalon-MM word address.
REQ-006 SHALL have port chipselect  input  1  slave select.
REQ-007 SHALL have port write_n  input  1  active-low write strobe.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port readdata  output  32  read data, combinational, zero wait states.
REQ-010 SHALL have port out_port  output  WIDTH  driven channel levels.

Function
REQ-011 SHALL perform a write when chipselect=1 and write_n=0, at most one write per cycle, effective on that clock edge.
REQ-012 SHALL implement register map: 0 DATA (rw), 1 SET (wo), 2 CLEAR (wo), 3 TOGGLE (wo), 4 BLINK_EN (rw), 5 PERIOD (rw), 6 STATUS (ro), 7 reserved.
REQ-013 SHALL on DATA write load data_out <= writedata[WIDTH-1:0].
REQ-014 SHALL on SET write apply data_out <= data_out | writedata[WIDTH-1:0].
REQ-015 SHALL on CLEAR write apply data_out <= data_out & ~writedata[WIDTH-1:0].
REQ-016 SHALL on TOGGLE write apply data_out <= data_out ^ writedata[WIDTH-1:0].
REQ-017 SHALL on BLINK_EN write load blink_en <= writedata[WIDTH-1:0].
REQ-018 SHALL on PERIOD write load period <= writedata[PRESCALE_W-1:0], clear counter to 0 and phase to 0 on the same edge.
REQ-019 SHALL ignore writes to addresses 6 and 7 and writedata bits above WIDTH/PRESCALE_W.
REQ-020 SHALL while blink_en != 0 and no PERIOD write: counter == period -> counter <= 0, phase <= ~phase; else counter <= counter + 1.
REQ-021 SHALL while blink_en == 0 hold counter = 0 and phase = 0 (next cycle after mask cleared).
REQ-022 SHALL with period = 0 toggle phase every cycle; half-period is period+1 clocks.
REQ-023 SHALL drive out_port = data_out ^ (blink_en & {WIDTH{phase}}), combinational from registers.
REQ-024 SHALL return readdata zero-extended: addr0 data_out, addr4 blink_en, addr5 period, addr6 {30'b0, (blink_en!=0), phase}, addr1/2/3/7 zero.
REQ-025 SHALL return readdata independent of chipselect and write_n (address-decoded only).
REQ-026 SHALL give a PERIOD write priority over a simultaneous counter wrap; a SET/CLEAR/TOGGLE/DATA write does not disturb counter or phase.

Reset
REQ-027 SHALL on reset=1 at a clock edge set data_out=0, blink_en=0, period=0, counter=0, phase=0, overriding any concurrent write.
REQ-028 SHALL after reset drive out_port=0 and readdata=0 for every address.
REQ-029 SHALL resume normal operation on the first edge with reset=0; mid-blink reset aborts blink immediately.

Verification
REQ-030 SHALL cover: reset, write DATA=0x3FF, read addr0 -> readdata=0x3FF, out_port=0x3FF; write DATA=0xFFFF_FFFF -> readdata=0x3FF.
REQ-031 SHALL cover: DATA=0x0F0, SET 0x003 -> 0x0F3, CLEAR 0x030 -> 0x0C3, TOGGLE 0x101 -> 0x1C2; reads of addr1/2/3 -> 0.
REQ-032 SHALL cover: DATA=0, PERIOD=3, BLINK_EN=0x001 -> out_port[0] 0 for 4 clocks, 1 for 4 clocks, repeating; STATUS bit1=1.
REQ-033 SHALL cover: PERIOD=0, BLINK_EN=0x3FF, DATA=0x0AA -> out_port alternates 0x0AA/0x355 every cycle; clear BLINK_EN -> 0x0AA steady, STATUS=0.
REQ-034 SHALL cover: PERIOD write on cycle of counter wrap -> phase=0, counter=0 next cycle, no toggle.
REQ-035 SHALL cover: reset asserted with concurrent write to DATA=0x155 while blinking -> all registers 0, out_port=0 next cycle.
